booth_controller: RTL

//  Control FSM for the 16-bit radix-2 Booth datapath. It accepts an operand-ready

---
 rtl/booth_controller_if.sv | 30 +++
 rtl/booth_controller.sv | 101 ++++++++++
 2 files changed

// File: rtl/booth_controller_if.sv
// Handshake and strobe bundle between the Booth controller, the datapath and the consumer.
`timescale 1ns/1ps
interface booth_controller_if;
    logic start_valid;
    logic start_ready;
    logic count;
    logic load;
    logic enable_A;
    logic enable_B;
    logic load_PP;
    logic enable_PP;
    logic load_P;
    logic out_valid;
    logic out_ready;
    logic busy;
    logic err;
    logic err_clear;

    modport master (
        input  start_valid, count, out_ready, err_clear,
        output start_ready, load, enable_A, enable_B, load_PP, enable_PP, load_P,
        output out_valid, busy, err
    );

    modport slave (
        output start_valid, count, out_ready, err_clear,
        input  start_ready, load, enable_A, enable_B, load_PP, enable_PP, load_P,
        input  out_valid, busy, err
    );
endinterface

// File: rtl/booth_controller.sv
// Sequencing FSM for the 16-bit radix-2 Booth datapath: load, init, iterate, capture,
// then hold the result until the consumer takes it. Sequencing faults park in ERR.
`timescale 1ns/1ps
module booth_controller #(
    parameter int unsigned ITERATIONS = 16,
    parameter int unsigned SLACK      = 2,
    parameter int unsigned CNT_W      = $clog2(ITERATIONS + SLACK + 1)
) (
    input logic               clk,
    input logic               reset,
    booth_controller_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StInit,
        StIter,
        StCapture,
        StDone,
        StErr
    } state_e;

    localparam logic [CNT_W-1:0] IterDone = CNT_W'(ITERATIONS);
    localparam logic [CNT_W-1:0] IterMax  = CNT_W'(ITERATIONS + SLACK);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        iter_cnt_d    = iter_cnt_q;
        bus.start_ready = 1'b0;
        bus.load      = 1'b0;
        bus.enable_A  = 1'b0;
        bus.enable_B  = 1'b0;
        bus.load_PP   = 1'b0;
        bus.enable_PP = 1'b0;
        bus.load_P    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.start_ready = 1'b1;
                if (bus.start_valid) state_d = StLoad;
            end
            StLoad: begin
                bus.load     = 1'b1;
                bus.enable_A = 1'b1;
                bus.enable_B = 1'b1;
                bus.busy     = 1'b1;
                iter_cnt_d   = '0;
                state_d      = StInit;
            end
            StInit: begin
                bus.load_PP = 1'b1;
                bus.busy    = 1'b1;
                state_d     = StIter;
            end
            StIter: begin
                bus.busy = 1'b1;
                if (bus.count) begin
                    state_d = (iter_cnt_q >= IterDone) ? StCapture : StErr;
                end else if (iter_cnt_q == IterMax) begin
                    // Timeout: the step budget is spent, so no further enable_PP.
                    state_d = StErr;
                end else begin
                    bus.enable_PP = 1'b1;
                    iter_cnt_d    = iter_cnt_q + 1'b1;
                end
            end
            StCapture: begin
                bus.load_P = 1'b1;
                bus.busy   = 1'b1;
                state_d    = StDone;
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = StIdle;
            end
            StErr: begin
                bus.err = 1'b1;
                if (bus.err_clear) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
